multi_cycle_ctrl: RTL

Sequencing controller for the multi-cycle RV32I core. It steps each instruction through fetch, decode, execute, memory and write-back, and handshakes with the instruction and data memory ports. It also gates the decode stage's register write and PC update so that each happens exactly once per instruction. It sits beside the fetch, decode, ALU, LSU and write-back datapath, and owns every architectural-state enable in the core.

---
 rtl/multi_cycle_ctrl_if.sv | 33 +++
 rtl/multi_cycle_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl_if.sv
// Instruction-fetch and data-memory handshake bundle for the multi-cycle controller.
// The master side is the controller; the slave side is the memory/fetch datapath.
interface multi_cycle_ctrl_if;

  logic ifu_o_req_valid;
  logic ifu_i_req_ready;
  logic ifu_i_resp_valid;
  logic lsu_o_req_valid;
  logic lsu_o_wen;
  logic lsu_i_req_ready;
  logic lsu_i_resp_valid;

  modport master (
    output ifu_o_req_valid,
    input  ifu_i_req_ready,
    input  ifu_i_resp_valid,
    output lsu_o_req_valid,
    output lsu_o_wen,
    input  lsu_i_req_ready,
    input  lsu_i_resp_valid
  );

  modport slave (
    input  ifu_o_req_valid,
    output ifu_i_req_ready,
    output ifu_i_resp_valid,
    input  lsu_o_req_valid,
    input  lsu_o_wen,
    output lsu_i_req_ready,
    output lsu_i_resp_valid
  );

endinterface

// File: rtl/multi_cycle_ctrl.sv
// Sequencing controller for the multi-cycle RV32I core. Steps each instruction through
// fetch, decode, execute, memory and write-back, and owns every architectural-state enable.
module multi_cycle_ctrl #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  multi_cycle_ctrl_if.master   bus,
  output logic                 ctrl_o_instr_wen,
  input  logic [3:0]           decode_i_mem_rw,
  input  logic                 decode_i_wb_reg_wen,
  input  logic                 decode_i_need_jump,
  input  logic                 ebreak_i,
  output logic                 ctrl_o_reg_wen,
  output logic                 ctrl_o_pc_wen,
  output logic                 ctrl_o_take_jump,
  output logic                 ctrl_o_retire,
  output logic [31:0]          ctrl_o_retire_cnt,
  output logic                 ctrl_o_halt,
  output logic [1:0]           ctrl_o_err,
  output logic [2:0]           ctrl_o_state
);

  // Halt causes
  localparam logic [1:0] ErrEbreak  = 2'd0;
  localparam logic [1:0] ErrFetchTo = 2'd1;
  localparam logic [1:0] ErrLsuTo   = 2'd2;
  localparam logic [1:0] ErrIllegal = 2'd3;

  // 17 bits so the compare against wd_q + 1 cannot wrap at TIMEOUT = 65535.
  localparam logic [16:0] TimeoutCnt = 17'(TIMEOUT);

  typedef enum logic [3:0] {
    StReset   = 4'd0,
    StIfReq   = 4'd1,
    StIfWait  = 4'd2,
    StId      = 4'd3,
    StEx      = 4'd4,
    StMemReq  = 4'd5,
    StMemWait = 4'd6,
    StWb      = 4'd7,
    StHalt    = 4'd8
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  err_q, err_d;
  logic        jump_q, jump_d;
  logic        store_q, store_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [15:0] wd_q, wd_d;

  logic        timeout;
  logic        waiting;
  logic        is_store;
  logic        is_illegal;

  logic        ifu_req_valid;
  logic        lsu_req_valid;
  logic        lsu_wen;

  // Decode of the memory access code presented during EX.
  always_comb begin
    is_store   = (decode_i_mem_rw >= 4'd6) && (decode_i_mem_rw <= 4'd8);
    is_illegal = (decode_i_mem_rw >= 4'd9);
  end

  // Next-state logic: FSM sequencing, watchdog, halt cause, jump/store flags, retire count.
  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    jump_d       = jump_q;
    store_d      = store_q;
    retire_cnt_d = retire_cnt_q;
    waiting      = 1'b0;
    // Fires on the TIMEOUT-th cycle spent in a wait state.
    timeout      = ({1'b0, wd_q} + 17'd1) == TimeoutCnt;

    unique case (state_q)
      StReset: state_d = StIfReq;
      StIfReq: begin
        waiting = 1'b1;
        if (bus.ifu_i_req_ready) begin
          state_d = StIfWait;
        end else if (timeout) begin
          state_d = StHalt;
          err_d   = ErrFetchTo;
        end
      end
      StIfWait: begin
        waiting = 1'b1;
        if (bus.ifu_i_resp_valid) begin
          state_d = StId;
        end else if (timeout) begin
          state_d = StHalt;
          err_d   = ErrFetchTo;
        end
      end
      StId: state_d = StEx;
      StEx: begin
        jump_d  = decode_i_need_jump;
        store_d = is_store;
        if (ebreak_i) begin
          state_d = StHalt;
          err_d   = ErrEbreak;
        end else if (is_illegal) begin
          state_d = StHalt;
          err_d   = ErrIllegal;
        end else if (decode_i_mem_rw != 4'd0) begin
          state_d = StMemReq;
        end else begin
          state_d = StWb;
        end
      end
      StMemReq: begin
        waiting = 1'b1;
        if (bus.lsu_i_req_ready) begin
          state_d = StMemWait;
        end else if (timeout) begin
          state_d = StHalt;
          err_d   = ErrLsuTo;
        end
      end
      StMemWait: begin
        waiting = 1'b1;
        if (bus.lsu_i_resp_valid) begin
          state_d = StWb;
        end else if (timeout) begin
          state_d = StHalt;
          err_d   = ErrLsuTo;
        end
      end
      StWb: begin
        retire_cnt_d = retire_cnt_q + 32'd1;
        state_d      = StIfReq;
      end
      StHalt: state_d = StHalt;
      default: state_d = StReset;
    endcase

    // Any state change restarts the watchdog, so entry to a wait state sees zero.
    if (state_d != state_q) begin
      wd_d = 16'd0;
    end else if (waiting) begin
      wd_d = wd_q + 16'd1;
    end else begin
      wd_d = wd_q;
    end
  end

  // State and bookkeeping registers, cleared asynchronously by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StReset;
      err_q        <= 2'd0;
      jump_q       <= 1'b0;
      store_q      <= 1'b0;
      retire_cnt_q <= 32'd0;
      wd_q         <= 16'd0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      jump_q       <= jump_d;
      store_q      <= store_d;
      retire_cnt_q <= retire_cnt_d;
      wd_q         <= wd_d;
    end
  end

  // Moore output decode; instr_wen additionally qualified by the fetch response.
  always_comb begin
    ifu_req_valid    = 1'b0;
    lsu_req_valid    = 1'b0;
    lsu_wen          = 1'b0;
    ctrl_o_instr_wen = 1'b0;
    ctrl_o_reg_wen   = 1'b0;
    ctrl_o_pc_wen    = 1'b0;
    ctrl_o_take_jump = 1'b0;
    ctrl_o_retire    = 1'b0;
    ctrl_o_halt      = 1'b0;
    ctrl_o_state     = state_q[2:0];

    unique case (state_q)
      StIfReq:  ifu_req_valid = 1'b1;
      StIfWait: ctrl_o_instr_wen = bus.ifu_i_resp_valid;
      StMemReq: begin
        lsu_req_valid = 1'b1;
        lsu_wen       = store_q;
      end
      StWb: begin
        ctrl_o_reg_wen   = decode_i_wb_reg_wen;
        ctrl_o_pc_wen    = 1'b1;
        ctrl_o_take_jump = jump_q;
        ctrl_o_retire    = 1'b1;
      end
      StHalt: begin
        ctrl_o_halt  = 1'b1;
        ctrl_o_state = 3'd0;
      end
      default: ;
    endcase
  end

  assign bus.ifu_o_req_valid = ifu_req_valid;
  assign bus.lsu_o_req_valid = lsu_req_valid;
  assign bus.lsu_o_wen       = lsu_wen;
  assign ctrl_o_retire_cnt   = retire_cnt_q;
  // Halt cause is only meaningful while halted; held at 0 otherwise.
  assign ctrl_o_err          = ctrl_o_halt ? err_q : 2'd0;

endmodule
